// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// The key map is indexed [row][col] and the helpers decode a one-cold column pattern.
package keypad_pkg;

  localparam int NUM_LINES = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } state_t;

  // Packed as {row3, row2, row1, row0}; each row is {col3, col2, col1, col0}.
  localparam logic [NUM_LINES-1:0][NUM_LINES-1:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic single_zero(input logic [3:0] p);
    return (p == 4'b1110) || (p == 4'b1101) || (p == 4'b1011) || (p == 4'b0111);
  endfunction

  function automatic logic [1:0] zero_index(input logic [3:0] p);
    logic [1:0] idx;
    case (p)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a single-cycle scan enable every 2^SCAN_DIV_BITS clocks.
// The enable is a clock-enable for logic in the clk domain, not a derived clock.
module scan_tick_gen #(
  parameter int SCAN_DIV_BITS = 11
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [SCAN_DIV_BITS-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else     div <= div + 1'b1;
  end

  // High on the last count, so the divider wraps on the same edge the tick is consumed.
  assign tick = &div;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad reader with debounce; reports the accepted key as a hex code.
// Press-to-key_valid is at most (3 + DEBOUNCE_TICKS) scan ticks plus 2 clk of synchroniser.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 11,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int             CW         = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0]  COUNT_DONE = CW'(DEBOUNCE_TICKS);

  logic          tick;
  logic [3:0]    sync1;
  logic [3:0]    cs;
  state_t        state, state_nxt;
  logic [1:0]    row_idx, row_nxt;
  logic [3:0]    pat, pat_nxt;
  logic [CW-1:0] count, count_nxt, count_inc;
  logic [3:0]    key_code_nxt;
  logic          key_valid_nxt;
  logic          key_held_nxt;

  scan_tick_gen #(
    .SCAN_DIV_BITS(SCAN_DIV_BITS)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'hF;
      cs    <= 4'hF;
    end else begin
      sync1 <= cols;
      cs    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      pat       <= 4'hF;
      count     <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_idx   <= row_nxt;
      pat       <= pat_nxt;
      count     <= count_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
    end
  end

  assign rows      = ~(4'b0001 << row_idx);
  assign count_inc = count + 1'b1;

  // The row stays parked while debouncing or pressed, so row_idx doubles as the latched row
  // and the latched column pattern identifies the column.
  always_comb begin
    state_nxt     = state;
    row_nxt       = row_idx;
    pat_nxt       = pat;
    count_nxt     = count;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;
    key_held_nxt  = key_held;

    if (tick) begin
      case (state)
        SCAN: begin
          if (single_zero(cs)) begin
            pat_nxt = cs;
            if (DEBOUNCE_TICKS == 1) begin
              key_code_nxt  = KEY_MAP[row_idx][zero_index(cs)];
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              count_nxt     = '0;
              state_nxt     = PRESSED;
            end else begin
              count_nxt = CW'(1);
              state_nxt = DEBOUNCE;
            end
          end else begin
            row_nxt = row_idx + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (cs == pat) begin
            if (count_inc == COUNT_DONE) begin
              key_code_nxt  = KEY_MAP[row_idx][zero_index(pat)];
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              count_nxt     = '0;
              state_nxt     = PRESSED;
            end else begin
              count_nxt = count_inc;
            end
          end else begin
            count_nxt = '0;
            row_nxt   = row_idx + 1'b1;
            state_nxt = SCAN;
          end
        end

        PRESSED: begin
          // Only a clean all-released sample counts; other keys or ghosts restart the count.
          if (cs == 4'hF) begin
            if (count_inc == COUNT_DONE) begin
              key_held_nxt = 1'b0;
              count_nxt    = '0;
              row_nxt      = row_idx + 1'b1;
              state_nxt    = SCAN;
            end else begin
              count_nxt = count_inc;
            end
          end else begin
            count_nxt = '0;
          end
        end

        default: begin
          count_nxt = '0;
          state_nxt = SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a key_valid scoreboard.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;            // bit r*4+c = key at row r, column c is pressed
  logic [3:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(
    .SCAN_DIV_BITS (2),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cols     (cols),
    .rows     (rows),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  // Scoreboard monitor: every key_valid pulse must match the next expected code.
  always @(negedge clk) begin
    logic [3:0] exp_code;
    if (key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid actual_code=%h required=no_pulse", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          errors++;
          $display("FAIL pulse_code actual=%h required=%h", key_code, exp_code);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_held(input logic val, input string name);
    int n = 0;
    while (key_held !== val && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, {3'b0, key_held}, {3'b0, val});
  endtask

  task automatic wait_rows(input logic [3:0] val, input string name);
    int n = 0;
    while (rows !== val && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, rows, val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] exp_rows;
    logic [3:0] seen;
    logic       held_seen;
    int         n;

    rst  = 1'b1;
    keys = '0;
    repeat (2) @(negedge clk);
    check("reset_rows", rows, 4'b1110);
    check("reset_code", key_code, 4'h0);
    check("reset_valid", {3'b0, key_valid}, 4'h0);
    check("reset_held", {3'b0, key_held}, 4'h0);
    rst = 1'b0;

    // Idle scanning: each row is driven for exactly 4 clocks, rotating 0->1->2->3.
    wait_rows(4'b1101, "idle_align");
    exp_rows = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      check("idle_row_start", rows, exp_rows);
      repeat (3) @(negedge clk);
      check("idle_row_end", rows, exp_rows);
      @(negedge clk);
      exp_rows = {exp_rows[2:0], exp_rows[3]};
    end
    check("idle_code", key_code, 4'h0);

    // Stable press of row1/col2.
    exp_q.push_back(4'h6);
    keys[1*4+2] = 1'b1;
    wait_held(1'b1, "press6_held");
    check("press6_code", key_code, 4'h6);
    for (int i = 0; i < 8; i++) begin
      check("press6_rows_parked", rows, 4'b1101);
      @(negedge clk);
    end
    keys = '0;
    wait_held(1'b0, "release6_held");

    // Release timing for row3/col1: held falls 11..14 clk after release.
    exp_q.push_back(4'h0);
    keys[3*4+1] = 1'b1;
    wait_held(1'b1, "press0_held");
    repeat (8) @(negedge clk);
    keys = '0;
    repeat (10) @(negedge clk);
    check("release0_held_early", {3'b0, key_held}, 4'h1);
    n = 0;
    while (key_held && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("release0_held_fall", {3'b0, key_held}, 4'h0);
    check("release0_code", key_code, 4'h0);
    check("release0_rows_resume", rows, 4'b1110);

    // Bouncing row0/col3: toggles every 4 clk, ends pressed; pulse expected only afterwards.
    for (int i = 0; i < 5; i++) begin
      keys[0*4+3] = ~keys[0*4+3];
      repeat (4) @(negedge clk);
    end
    exp_q.push_back(4'hA);
    wait_held(1'b1, "bounceA_held");
    check("bounceA_code", key_code, 4'hA);
    keys = '0;
    wait_held(1'b0, "bounceA_release");

    // Two keys in row2: ghost pattern, nothing accepted and scanning continues.
    keys = 16'h0300;
    seen = 4'h0;
    held_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | ~rows;
      if (key_held) held_seen = 1'b1;
    end
    check("ghost_rows_scanned", seen, 4'hF);
    check("ghost_no_held", {3'b0, held_seen}, 4'h0);
    keys = '0;
    repeat (8) @(negedge clk);

    // Key 5 held, then key 4 in the same row added: no new pulse, code stays 5.
    exp_q.push_back(4'h5);
    keys[1*4+1] = 1'b1;
    wait_held(1'b1, "hold5_held");
    keys[1*4+0] = 1'b1;
    repeat (40) @(negedge clk);
    check("hold5_code", key_code, 4'h5);
    check("hold5_still_held", {3'b0, key_held}, 4'h1);
    keys = '0;
    wait_held(1'b0, "hold5_release");

    // Reset in the middle of debouncing key 9 (row2/col2).
    wait_rows(4'b1110, "rst9_align_row0");
    keys[2*4+2] = 1'b1;
    wait_rows(4'b1011, "rst9_align_row2");
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst9_rows", rows, 4'b1110);
    check("rst9_code", key_code, 4'h0);
    check("rst9_valid", {3'b0, key_valid}, 4'h0);
    check("rst9_held", {3'b0, key_held}, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'h9);
    wait_held(1'b1, "rst9_redetect_held");
    check("rst9_redetect_code", key_code, 4'h9);
    keys = '0;
    wait_held(1'b0, "rst9_release");

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_key_valid actual_pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
